// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies, FSM states.
// MDU_MADD_EN enables the MADD op (encoding 6).
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;

  localparam int unsigned DEF_MULT_LAT = 5;
  localparam int unsigned DEF_DIV_LAT  = 10;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } mdu_state_e;

  // Ops that the unit acts on; anything else is ignored and never stalls.
  function automatic logic op_supported(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return (op <= MD_MTLO) || (op == MD_MADD);
`else
    return (op <= MD_MTLO);
`endif
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational datapath: 64-bit product or quotient/remainder from A, B and op.
// MDU_MADD_EN: MADD shares the signed product path.
module mdu_core
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic               is_div;

  always_comb begin
    is_div   = (op == MD_DIV) || (op == MD_DIVU);
    div_zero = is_div && (b == '0);
    // Divide by one when B is zero so the quotient never goes X; the result is discarded anyway.
    divisor  = (b == '0) ? 32'd1 : b;
    prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u   = {32'd0, a} * {32'd0, b};
    quot_s   = $signed(a) / $signed(divisor);
    rem_s    = $signed(a) % $signed(divisor);
    quot_u   = a / divisor;
    rem_u    = a % divisor;
    hi       = '0;
    lo       = '0;
    case (op)
      MD_MULT, MD_MADD: {hi, lo} = prod_s;
      MD_MULTU:         {hi, lo} = prod_u;
      MD_DIV: begin
        hi = rem_s;
        lo = quot_s;
      end
      MD_DIVU: begin
        hi = rem_u;
        lo = quot_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: fixed-latency busy counter, shadow result, HI/LO ownership.
// MDU_MADD_EN enables MADD ({HI,LO} += signed A*B, accumulated at commit).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MD_Start,
  input  logic [2:0]  MD_Op,
  input  logic        MD_Read,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Stall_E,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      sh_hi;
  logic [31:0]      sh_lo;
  logic             sh_skip;
  logic             sh_acc;

  logic [31:0]      core_hi;
  logic [31:0]      core_lo;
  logic             core_div_zero;
  logic             lat_op;
  logic             div_op;

  mdu_core u_core (
    .op       (MD_Op),
    .a        (A),
    .b        (B),
    .hi       (core_hi),
    .lo       (core_lo),
    .div_zero (core_div_zero)
  );

  always_comb begin
    div_op = (MD_Op == MD_DIV) || (MD_Op == MD_DIVU);
`ifdef MDU_MADD_EN
    lat_op = (MD_Op <= MD_DIVU) || (MD_Op == MD_MADD);
`else
    lat_op = (MD_Op <= MD_DIVU);
`endif
    Stall_E = ((MD_Start && op_supported(MD_Op)) || MD_Read) && Busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      Busy    <= 1'b0;
      cnt     <= '0;
      sh_hi   <= '0;
      sh_lo   <= '0;
      sh_skip <= 1'b0;
      sh_acc  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (MD_Start && lat_op) begin
            sh_hi   <= core_hi;
            sh_lo   <= core_lo;
            sh_skip <= core_div_zero;
            sh_acc  <= (MD_Op == MD_MADD);
            cnt     <= div_op ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            state   <= S_BUSY;
            Busy    <= 1'b1;
          end else if (MD_Start && MD_Op == MD_MTHI) begin
            HI <= A;
          end else if (MD_Start && MD_Op == MD_MTLO) begin
            LO <= A;
          end
        end
        S_BUSY: begin
          if (cnt == CNT_W'(1)) begin
            // MADD reads HI/LO here, not at issue, so it accumulates onto the committed value.
            if (!sh_skip) begin
              if (sh_acc) {HI, LO} <= {HI, LO} + {sh_hi, sh_lo};
              else begin
                HI <= sh_hi;
                LO <= sh_lo;
              end
            end
            cnt   <= '0;
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected HI/LO/latency, a monitor checks each commit.
// Exercises MADD when compiled with MDU_MADD_EN, otherwise checks op 6 is ignored.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MD_Start;
  logic [2:0]  MD_Op;
  logic        MD_Read;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Stall_E;
  logic [31:0] HI;
  logic [31:0] LO;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .MD_Start (MD_Start),
    .MD_Op    (MD_Op),
    .MD_Read  (MD_Read),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Stall_E  (Stall_E),
    .HI       (HI),
    .LO       (LO)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: a falling Busy outside reset is a commit; compare against the oldest expectation.
  logic prev_busy = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      bcnt = 0;
    end else if (Busy) begin
      bcnt++;
    end else if (prev_busy) begin
      if (sb.size() == 0) begin
        chk("unexpected_commit", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"}, HI, e.hi);
        chk({e.name, "_lo"}, LO, e.lo);
        chk({e.name, "_busy_cycles"}, 32'(bcnt), 32'(e.lat));
      end
      bcnt = 0;
    end
    prev_busy = Busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo, input int lat);
    exp_t e;
    e.name = name;
    e.hi   = hi;
    e.lo   = lo;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; the op is accepted at the next edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MD_Start = 1'b1;
    MD_Op    = op;
    A        = a;
    B        = b;
    step();
    MD_Start = 1'b0;
  endtask

  task automatic wait_idle(output int stalls);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!Busy) return;
      if (Stall_E) stalls++;
    end
    chk("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    reset    = 1'b1;
    MD_Start = 1'b0;
    MD_Op    = '0;
    MD_Read  = 1'b0;
    A        = '0;
    B        = '0;
    repeat (2) step();
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    reset   = 1'b0;
    MD_Read = 1'b1;
    #1;
    chk("idle_read_stall", 32'(Stall_E), 32'd0);
    MD_Read = 1'b0;
    step();

    // MULT -3 * 7 = -21
    push("mult", 32'hFFFFFFFF, 32'hFFFFFFEB, 5);
    issue(MD_MULT, 32'hFFFFFFFD, 32'd7);
    wait_idle(s);
    chk("mult_stall", 32'(s), 32'd0);
    step();

    // DIVU 100 / 7 with MFLO waiting in E
    push("divu", 32'd2, 32'd14, 10);
    MD_Read = 1'b1;
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_idle(s);
    chk("divu_read_stall", 32'(s), 32'd10);
    chk("divu_stall_release", 32'(Stall_E), 32'd0);
    MD_Read = 1'b0;
    step();

    // DIV -7 / 2 = -3 rem -1, then divide by zero leaves HI/LO alone
    push("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(s);
    step();
    push("div0", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(MD_DIV, 32'd5, 32'd0);
    wait_idle(s);
    step();

    // MTHI while idle
    issue(MD_MTHI, 32'h1234, 32'd0);
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_lo", LO, 32'hFFFFFFFD);
    chk("mthi_busy", 32'(Busy), 32'd0);

    // MTLO presented while MULTU 3*5 is in flight
    push("multu", 32'd0, 32'd15, 5);
    issue(MD_MULTU, 32'd3, 32'd5);
    MD_Start = 1'b1;
    MD_Op    = MD_MTLO;
    A        = 32'hABCD;
    s        = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!Stall_E) break;
      s++;
    end
    chk("mtlo_stall", 32'(s), 32'd5);
    step();
    MD_Start = 1'b0;
    chk("mtlo_lo", LO, 32'hABCD);
    chk("mtlo_hi", HI, 32'd0);

    // Reserved op 7 does nothing
    issue(3'd7, 32'hDEAD, 32'hBEEF);
    chk("rsvd_busy", 32'(Busy), 32'd0);
    chk("rsvd_lo", LO, 32'hABCD);

    // Reset three cycles into a MULT aborts it
    issue(MD_MULT, 32'd2, 32'd2);
    repeat (2) step();
    chk("pre_reset_busy", 32'(Busy), 32'd1);
    reset = 1'b1;
    step();
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    step();
    reset = 1'b0;
    repeat (12) step();
    chk("abort_late_hi", HI, 32'd0);
    chk("abort_late_lo", LO, 32'd0);

    // MADD onto HI=0 LO=10
    issue(MD_MTLO, 32'd10, 32'd0);
    chk("madd_setup_lo", LO, 32'd10);
`ifdef MDU_MADD_EN
    push("madd", 32'd0, 32'd30, 5);
    issue(MD_MADD, 32'd4, 32'd5);
    wait_idle(s);
    step();
`else
    issue(MD_MADD, 32'd4, 32'd5);
    chk("op6_busy", 32'(Busy), 32'd0);
    repeat (6) step();
    chk("op6_hi", HI, 32'd0);
    chk("op6_lo", LO, 32'd10);
`endif

    repeat (2) step();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
